// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared pipeline definitions for the write-back stage
// Purpose: datapath width defaults, the hardwired-zero register index and the
//          MemtoReg select encoding. The MEM/WB register and the forwarding
//          unit use the same definitions.
// Ports:   none (package)
package wb_regfile_pkg;

  localparam int PL_DATA_W = 32;
  localparam int PL_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MemtoReg select encoding
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - write-back value select (load data or ALU result)
// Purpose: 2:1 combinational select of the value committed in write-back.
// Ports:   i_MemtoReg  select, SEL_MEM picks i_Rdata, SEL_ALU picks i_ALUresult
//          i_Rdata     data-memory read data
//          i_ALUresult ALU result
//          o_wb_data   selected write-back value
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = PL_DATA_W
) (
  input  logic              i_MemtoReg,
  input  logic [DATA_W-1:0] i_Rdata,
  input  logic [DATA_W-1:0] i_ALUresult,
  output logic [DATA_W-1:0] o_wb_data
);

  assign o_wb_data = (i_MemtoReg == SEL_MEM) ? i_Rdata : i_ALUresult;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 32-entry register file
// Purpose: selects the write-back value, commits it to the register file,
//          serves two combinational ID read ports with optional same-cycle
//          bypass, exports the write-back bus and counts retired writes.
// Ports:   i_clk, i_rst          clock, synchronous active-high reset
//          i_MemtoReg, i_RegWrite, i_Rdata, i_ALUresult, i_Reg_Dst
//                                registered MEM/WB outputs
//          i_rs_addr, i_rt_addr  ID read addresses
//          o_rs_data, o_rt_data  ID read data
//          o_wb_en, o_wb_addr, o_wb_data
//                                write-back bus to the forwarding unit
//          o_retire_cnt          effective writes since reset (wraps)
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W    = PL_DATA_W,
  parameter int ADDR_W    = PL_ADDR_W,
  parameter int NREG      = 32,
  parameter int BYPASS_EN = 1,
  parameter int CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_MemtoReg,
  input  logic              i_RegWrite,
  input  logic [DATA_W-1:0] i_Rdata,
  input  logic [DATA_W-1:0] i_ALUresult,
  input  logic [ADDR_W-1:0] i_Reg_Dst,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic              BYP       = (BYPASS_EN != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [CNT_W-1:0]  retire_cnt;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .i_MemtoReg (i_MemtoReg),
    .i_Rdata    (i_Rdata),
    .i_ALUresult(i_ALUresult),
    .o_wb_data  (wb_data)
  );

  // Writes to r0 are dropped here so they neither land nor count as retired.
  assign wb_en = i_RegWrite && (i_Reg_Dst != ZERO_ADDR);

  assign o_wb_en      = wb_en;
  assign o_wb_addr    = i_Reg_Dst;
  assign o_wb_data    = wb_data;
  assign o_retire_cnt = retire_cnt;

  // Reset wins over a coincident write: that write and its count are lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      retire_cnt <= '0;
    end else if (wb_en) begin
      regs[i_Reg_Dst] <= wb_data;
      retire_cnt      <= retire_cnt + CNT_W'(1);
    end
  end

  // Address 0 is resolved before touching the array, so r0 never depends on
  // array contents. The bypass lets ID see a value committing this same edge.
  always_comb begin
    o_rs_data = '0;
    if (i_rs_addr != ZERO_ADDR) begin
      if (BYP && wb_en && (i_rs_addr == i_Reg_Dst)) begin
        o_rs_data = wb_data;
      end else begin
        o_rs_data = regs[i_rs_addr];
      end
    end
  end

  always_comb begin
    o_rt_data = '0;
    if (i_rt_addr != ZERO_ADDR) begin
      if (BYP && wb_en && (i_rt_addr == i_Reg_Dst)) begin
        o_rt_data = wb_data;
      end else begin
        o_rt_data = regs[i_rt_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        memtoreg;
  logic        regwrite;
  logic [31:0] rdata;
  logic [31:0] alures;
  logic [4:0]  dst;
  logic [4:0]  rs;
  logic [4:0]  rt;

  logic [31:0] a_rs, a_rt, a_wbd, n_rs, n_rt, n_wbd, w_rs, w_rt, w_wbd;
  logic        a_wbe, n_wbe, w_wbe;
  logic [4:0]  a_wba, n_wba, w_wba;
  logic [31:0] a_cnt, n_cnt;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.BYPASS_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_MemtoReg(memtoreg), .i_RegWrite(regwrite),
    .i_Rdata(rdata), .i_ALUresult(alures), .i_Reg_Dst(dst),
    .i_rs_addr(rs), .i_rt_addr(rt), .o_rs_data(a_rs), .o_rt_data(a_rt),
    .o_wb_en(a_wbe), .o_wb_addr(a_wba), .o_wb_data(a_wbd), .o_retire_cnt(a_cnt)
  );

  wb_regfile #(.BYPASS_EN(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_MemtoReg(memtoreg), .i_RegWrite(regwrite),
    .i_Rdata(rdata), .i_ALUresult(alures), .i_Reg_Dst(dst),
    .i_rs_addr(rs), .i_rt_addr(rt), .o_rs_data(n_rs), .o_rt_data(n_rt),
    .o_wb_en(n_wbe), .o_wb_addr(n_wba), .o_wb_data(n_wbd), .o_retire_cnt(n_cnt)
  );

  wb_regfile #(.BYPASS_EN(1), .CNT_W(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_MemtoReg(memtoreg), .i_RegWrite(regwrite),
    .i_Rdata(rdata), .i_ALUresult(alures), .i_Reg_Dst(dst),
    .i_rs_addr(rs), .i_rt_addr(rt), .o_rs_data(w_rs), .o_rt_data(w_rt),
    .o_wb_en(w_wbe), .o_wb_addr(w_wba), .o_wb_data(w_wbd), .o_retire_cnt(w_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: architectural register contents and a retire count.
  logic [31:0] m_regs [32];
  longint      m_retired;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_wb_data();
    return memtoreg ? rdata : alures;
  endfunction

  function automatic logic m_wb_en();
    return (regwrite === 1'b1) && (dst != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && m_wb_en() && a == dst) return m_wb_data();
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_retired = 0;
      m_valid   = 1'b1;
    end else if (m_valid && m_wb_en()) begin
      m_regs[dst] = m_wb_data();
      m_retired   = m_retired + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("wb_en",      {31'h0, a_wbe}, {31'h0, m_wb_en()});
      chk("wb_addr",    {27'h0, a_wba}, {27'h0, dst});
      chk("wb_data",    a_wbd, m_wb_data());
      chk("rs_byp",     a_rs, m_read(rs, 1'b1));
      chk("rt_byp",     a_rt, m_read(rt, 1'b1));
      chk("cnt32",      a_cnt, m_retired[31:0]);
      chk("nb_wb_en",   {31'h0, n_wbe}, {31'h0, m_wb_en()});
      chk("nb_wb_data", n_wbd, m_wb_data());
      chk("rs_nobyp",   n_rs, m_read(rs, 1'b0));
      chk("rt_nobyp",   n_rt, m_read(rt, 1'b0));
      chk("nb_cnt",     n_cnt, m_retired[31:0]);
      chk("w_wb_en",    {31'h0, w_wbe}, {31'h0, m_wb_en()});
      chk("w_wb_addr",  {27'h0, w_wba}, {27'h0, dst});
      chk("w_wb_data",  w_wbd, m_wb_data());
      chk("w_rs",       w_rs, m_read(rs, 1'b1));
      chk("w_rt",       w_rt, m_read(rt, 1'b1));
      chk("cnt4",       {28'h0, w_cnt}, {28'h0, m_retired[3:0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; memtoreg = 1'b0; regwrite = 1'b0;
    rdata = 32'h0; alures = 32'h0; dst = 5'd0; rs = 5'd0; rt = 5'd0;

    // Reset for two edges, then sweep every address on both ports.
    step();
    step();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs = 5'(a);
      rt = 5'(31 - a);
      #1;
      chk("rst_rs", a_rs, 32'h0);
      chk("rst_rt", a_rt, 32'h0);
      step();
    end
    chk("rst_cnt", a_cnt, 32'h0);

    // ALU write-back to r5.
    regwrite = 1'b1; memtoreg = 1'b0; alures = 32'h0000_00AA; dst = 5'd5;
    rs = 5'd0; rt = 5'd0;
    step();
    regwrite = 1'b0; rs = 5'd5;
    #1;
    chk("alu_rs5", a_rs, 32'h0000_00AA);
    chk("alu_cnt", a_cnt, 32'd1);

    // Load write-back to r7 seen through the bypass before the edge.
    regwrite = 1'b1; memtoreg = 1'b1; rdata = 32'hDEAD_BEEF; dst = 5'd7;
    rs = 5'd7; rt = 5'd7;
    #1;
    chk("byp_rs",   a_rs, 32'hDEAD_BEEF);
    chk("byp_rt",   a_rt, 32'hDEAD_BEEF);
    chk("nobyp_rs", n_rs, 32'h0);
    chk("nobyp_rt", n_rt, 32'h0);
    step();
    regwrite = 1'b0;
    #1;
    chk("nobyp_after", n_rs, 32'hDEAD_BEEF);
    chk("load_cnt",    a_cnt, 32'd2);

    // Write to r0 is discarded.
    regwrite = 1'b1; memtoreg = 1'b0; alures = 32'hFFFF_FFFF; dst = 5'd0;
    rs = 5'd0; rt = 5'd0;
    #1;
    chk("r0_wb_en",   {31'h0, a_wbe}, 32'h0);
    chk("r0_wb_data", a_wbd, 32'hFFFF_FFFF);
    chk("r0_rs_pre",  a_rs, 32'h0);
    step();
    regwrite = 1'b0;
    #1;
    chk("r0_rs_post", a_rs, 32'h0);
    chk("r0_cnt",     a_cnt, 32'd2);

    // Reset coinciding with a write to r9: write lost, everything cleared.
    regwrite = 1'b1; memtoreg = 1'b0; alures = 32'h0000_1234; dst = 5'd9;
    rst = 1'b1;
    step();
    rst = 1'b0; regwrite = 1'b0; rs = 5'd9; rt = 5'd5;
    #1;
    chk("rstpri_r9",  a_rs, 32'h0);
    chk("rstpri_r5",  a_rt, 32'h0);
    chk("rstpri_cnt", a_cnt, 32'h0);
    chk("rstpri_w",   {28'h0, w_cnt}, 32'h0);

    // Sixteen writes to r3 wrap the 4-bit counter.
    rs = 5'd3; rt = 5'd7;
    for (int i = 0; i < 16; i++) begin
      regwrite = 1'b1; memtoreg = 1'b0; alures = 32'h100 + 32'(i); dst = 5'd3;
      step();
      regwrite = 1'b0;
      #1;
      if (i == 14) chk("wrap_15", {28'h0, w_cnt}, 32'd15);
      if (i == 15) chk("wrap_0",  {28'h0, w_cnt}, 32'd0);
    end
    chk("wrap_r3",    w_rs, 32'h0000_010F);
    chk("wrap_cnt32", a_cnt, 32'd16);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
